key_debounce: RTL and testbench

- Multi-channel push-button/switch conditioner for the DE2-70 board inputs.
- Synchronises raw asynchronous pins into the clk domain and filters contact bounce.
- Presents clean, glitch-free active-high levels to the downstream one-tick edge detectors that drive snake direction and game control.
- One instance serves all keys; each channel is independent.

---
 rtl/key_debounce.sv | 144 ++++++++++++++
 tb/tb_key_debounce.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: per-channel 2-FF synchroniser plus bounce filter FSM.
// Optional auto-repeat via KEY_DEBOUNCE_REPEAT_EN.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   key_raw     raw asynchronous pins (inverted first when ACTIVE_LOW=1)
//   db_level    registered, debounced active-high level per channel
//   repeat_tick one-cycle auto-repeat pulse per channel
//               (tied to 0 unless KEY_DEBOUNCE_REPEAT_EN is defined)
module key_debounce #(
  parameter int N_KEYS        = 4,
  parameter int DB_CYCLES     = 1000000,
  parameter int CNT_W         = 20,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] db_level,
  output logic [N_KEYS-1:0] repeat_tick
);

  localparam logic [1:0] IDLE0 = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] IDLE1 = 2'd2;
  localparam logic [1:0] WAIT0 = 2'd3;

  // The IDLE->WAIT transition already consumed one stable sample, so
  // WAIT accepts after DB_CYCLES-1 further samples: DB_CYCLES in total.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

  logic [N_KEYS-1:0] pin;
  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;

  assign pin = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifndef KEY_DEBOUNCE_REPEAT_EN
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             db_q;
    logic             db_nx;

    always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      case (state)
        IDLE0: if (s2[i]) state_nx = WAIT1;
        WAIT1: begin
          if (!s2[i])              state_nx = IDLE0;
          else if (cnt == CNT_LAST) state_nx = IDLE1;
          else                     cnt_nx   = cnt + 1'b1;
        end
        IDLE1: if (!s2[i]) state_nx = WAIT0;
        WAIT0: begin
          if (s2[i])               state_nx = IDLE1;
          else if (cnt == CNT_LAST) state_nx = IDLE0;
          else                     cnt_nx   = cnt + 1'b1;
        end
        default: state_nx = IDLE0;
      endcase
    end

    assign db_nx = (state_nx == IDLE1) || (state_nx == WAIT0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE0;
        cnt   <= '0;
        db_q  <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        db_q  <= db_nx;
      end
    end

    assign db_level[i] = db_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] R_DELAY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] R_PERIOD = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rnext;
    logic [RPT_W-1:0] rtarget;
    logic             armed;
    logic             stay;
    logic             tick_q;

    // Counting only while IDLE1 holds; the exit cycle clears silently.
    assign stay    = (state == IDLE1) && s2[i];
    assign rnext   = rcnt + 1'b1;
    assign rtarget = armed ? R_PERIOD : R_DELAY;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rcnt   <= '0;
        armed  <= 1'b0;
        tick_q <= 1'b0;
      end else if (!stay) begin
        rcnt   <= '0;
        armed  <= 1'b0;
        tick_q <= 1'b0;
      end else if (rnext == rtarget) begin
        rcnt   <= '0;
        armed  <= 1'b1;
        tick_q <= 1'b1;
      end else begin
        rcnt   <= rnext;
        tick_q <= 1'b0;
      end
    end

    assign repeat_tick[i] = tick_q;
`else
    assign repeat_tick[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scenario tasks checked against a sample-history model.
// Debounce rule modelled as "last DB samples seen by the filter all differ".
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int CW = 20;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] db_level;
  logic [NK-1:0] repeat_tick;

  int total = 0;
  int bad   = 0;

  // Model state: hist[i][j] = conditioned sample taken j edges ago.
  logic [63:0]   hist [NK];
  logic [NK-1:0] m_db   = '0;
  logic [NK-1:0] m_tick = '0;
  int            held [NK];
  int            age;
  bit            all_flip;

  key_debounce #(
    .N_KEYS(NK), .DB_CYCLES(DB), .CNT_W(CW), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(rst), .key_raw(key_raw),
    .db_level(db_level), .repeat_tick(repeat_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NK; i++) begin
        hist[i] = '0;
        held[i] = 0;
      end
      m_db   = '0;
      m_tick = '0;
    end else begin
      for (int i = 0; i < NK; i++) begin
        hist[i] = {hist[i][62:0], ~key_raw[i]};
        // The filter sees samples 2 edges old; flip after DB opposite ones.
        all_flip = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[i][j] == m_db[i]) all_flip = 1'b0;
        if (all_flip) m_db[i] = ~m_db[i];
        // Steady pressed state: level high and latest filtered sample high.
        if (m_db[i] && hist[i][2]) held[i] = held[i] + 1;
        else held[i] = 0;
        age = held[i] - 1;
        m_tick[i] = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        if (held[i] > 0 && age >= RD && ((age - RD) % RP) == 0)
          m_tick[i] = 1'b1;
`endif
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    key_raw = '1;
    repeat (3) @(negedge clk);
    total++;
    if (db_level !== '0 || repeat_tick !== '0) begin
      bad++;
      $display("FAIL reset_state db=%b tick=%b want 0000 0000",
               db_level, repeat_tick);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++;
      if (db_level !== 4'b0000 || repeat_tick !== 4'b0000) begin
        bad++;
        $display("FAIL idle_hold c=%0d db=%b tick=%b want 0000 0000",
                 c, db_level, repeat_tick);
      end
    end
  endtask

  task automatic test_press();
    int rise = -1;
    int fall = -1;
    key_raw[0] = 1'b0;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL press_model e=%0d db=%b tick=%b want %b %b",
                 e, db_level, repeat_tick, m_db, m_tick);
      end
      if (rise < 0 && db_level[0] === 1'b1) rise = e;
    end
    total++;
    if (rise != 9) begin
      bad++;
      $display("FAIL press_latency got=%0d want=9", rise);
    end
    key_raw[0] = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL release_model e=%0d db=%b tick=%b want %b %b",
                 e, db_level, repeat_tick, m_db, m_tick);
      end
      if (fall < 0 && db_level[0] === 1'b0) fall = e;
    end
    total++;
    if (fall != 9) begin
      bad++;
      $display("FAIL release_latency got=%0d want=9", fall);
    end
  endtask

  task automatic test_bounce();
    int rise = -1;
    for (int e = 0; e < 30; e++) begin
      key_raw[1] = (e >= 5 && e < 7) ? 1'b1 : 1'b0;
      @(negedge clk);
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL bounce_model e=%0d db=%b tick=%b want %b %b",
                 e, db_level, repeat_tick, m_db, m_tick);
      end
      if (rise < 0 && db_level[1] === 1'b1) rise = e;
    end
    total++;
    if (rise != 16) begin
      bad++;
      $display("FAIL bounce_latency got=%0d want=16", rise);
    end
    key_raw[1] = 1'b1;
    repeat (14) @(negedge clk);
    total++;
    if (db_level !== 4'b0000) begin
      bad++;
      $display("FAIL bounce_release db=%b want 0000", db_level);
    end
  endtask

  task automatic test_simultaneous();
    int rise2 = -1;
    bit saw3  = 1'b0;
    key_raw[2] = 1'b0;
    key_raw[3] = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (e == 3) key_raw[3] = 1'b1;
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL simul_model e=%0d db=%b tick=%b want %b %b",
                 e, db_level, repeat_tick, m_db, m_tick);
      end
      if (rise2 < 0 && db_level[2] === 1'b1) rise2 = e;
      if (db_level[3] !== 1'b0) saw3 = 1'b1;
    end
    total++;
    if (rise2 != 9 || saw3) begin
      bad++;
      $display("FAIL simul_channels rise2=%0d ch3_seen=%0d want 9 0",
               rise2, saw3);
    end
  endtask

  task automatic test_async_reset();
    int rise = -1;
    key_raw = 4'b1010;
    repeat (5) @(negedge clk);
    total++;
    if (db_level !== 4'b0100) begin
      bad++;
      $display("FAIL mid_wait db=%b want 0100", db_level);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (db_level !== 4'b0000 || repeat_tick !== 4'b0000) begin
      bad++;
      $display("FAIL async_clear db=%b tick=%b want 0000 0000",
               db_level, repeat_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL rst_model n=%0d db=%b tick=%b want %b %b",
                 n, db_level, repeat_tick, m_db, m_tick);
      end
      if (rise < 0 && db_level[0] === 1'b1) rise = n;
    end
    total++;
    if (rise != 10) begin
      bad++;
      $display("FAIL rst_latency got=%0d want=10", rise);
    end
  endtask

  task automatic test_repeat();
    int rise = -1;
    int ticks [$];
    bit late = 1'b0;
    key_raw = '1;
    repeat (14) @(negedge clk);
    key_raw[0] = 1'b0;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL repeat_model e=%0d db=%b tick=%b want %b %b",
                 e, db_level, repeat_tick, m_db, m_tick);
      end
      if (rise < 0 && db_level[0] === 1'b1) rise = e;
      if (repeat_tick[0] === 1'b1 && rise >= 0) ticks.push_back(e - rise);
    end
`ifdef KEY_DEBOUNCE_REPEAT_EN
    total++;
    if (ticks.size() < 3 || ticks[0] != 20 || ticks[1] != 25 ||
        ticks[2] != 30) begin
      bad++;
      $display("FAIL repeat_offsets n=%0d want 20,25,30", ticks.size());
    end
`else
    total++;
    if (ticks.size() != 0) begin
      bad++;
      $display("FAIL repeat_disabled n=%0d want 0", ticks.size());
    end
`endif
    key_raw[0] = 1'b1;
    for (int e = 0; e < 15; e++) begin
      @(negedge clk);
      if (repeat_tick !== 4'b0000) late = 1'b1;
    end
    total++;
    if (late) begin
      bad++;
      $display("FAIL repeat_after_release tick seen want none");
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(6, 0) == 0) key_raw[i] = ~key_raw[i];
      @(negedge clk);
      total++;
      if (db_level !== m_db || repeat_tick !== m_tick) begin
        bad++;
        $display("FAIL random_model c=%0d db=%b tick=%b want %b %b",
                 c, db_level, repeat_tick, m_db, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
